// File: rtl/floppy_rom_arbiter.sv
// Round-robin arbiter sharing the disk-image ROM read port between the
// internal (requester 0) and external (requester 1) floppy drive models.
// One memory transaction runs at a time; a watchdog aborts a transaction
// whose memory ack never arrives and returns 8'hFF to the drive instead.
module floppy_rom_arbiter #(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  _reset,
  // Internal drive
  input  logic                  req0Valid,
  input  logic [ADDR_WIDTH-1:0] req0Addr,
  output logic                  req0Ack,
  output logic [7:0]            req0Data,
  // External drive
  input  logic                  req1Valid,
  input  logic [ADDR_WIDTH-1:0] req1Addr,
  output logic                  req1Ack,
  output logic [7:0]            req1Data,
  // Disk-image memory read port
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memAck,
  input  logic [7:0]            memData,
  // Status
  output logic                  busy,
  output logic                  owner,
  output logic                  timeoutErr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned    CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [1:0]            state_q,      state_d;
  logic                  mem_req_q,    mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic                  owner_q,      owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CntW-1:0]       cnt_q,        cnt_d;
  logic                  ack0_q,       ack0_d;
  logic                  ack1_q,       ack1_d;
  logic [7:0]            data0_q,      data0_d;
  logic [7:0]            data1_q,      data1_d;
  logic                  tmo_q,        tmo_d;

  logic                  any_valid;
  logic                  grantee;
  logic                  owner_valid;
  logic                  finish;
  logic [7:0]            resp_data;

  // Grant selection: a lone requester wins; on a tie, the one not served last wins.
  always_comb begin
    any_valid   = req0Valid | req1Valid;
    grantee     = (req0Valid && req1Valid) ? ~last_grant_q : req1Valid;
    owner_valid = owner_q ? req1Valid : req0Valid;
  end

  // Next-state logic for the IDLE -> WAIT -> RESP transaction sequence.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    data0_d      = data0_q;
    data1_d      = data1_q;
    tmo_d        = 1'b0;
    finish       = 1'b0;
    resp_data    = 8'h00;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d      = grantee;
          last_grant_d = grantee;
          mem_addr_d   = grantee ? req1Addr : req0Addr;
          mem_req_d    = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT;
        end
      end

      WAIT: begin
        // A real ack always beats the watchdog, even on the final count.
        if (memAck) begin
          finish    = 1'b1;
          resp_data = memData;
        end else if (cnt_q == CntLast) begin
          finish    = 1'b1;
          resp_data = 8'hFF;
          tmo_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (finish) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          // The ack and data registers are loaded on entry to RESP so that both
          // are visible together for the whole RESP cycle. An owner that has
          // already dropped its request gets nothing and keeps its old byte.
          if (owner_valid) begin
            if (owner_q) begin
              ack1_d  = 1'b1;
              data1_d = resp_data;
            end else begin
              ack0_d  = 1'b1;
              data0_d = resp_data;
            end
          end
        end
      end

      RESP: begin
        // Mandatory idle cycle follows; late memory acks are ignored here.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops memReq immediately and loses any transaction.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      data0_q      <= 8'h00;
      data1_q      <= 8'h00;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      tmo_q        <= tmo_d;
    end
  end

  // Output mapping.
  always_comb begin
    memReq     = mem_req_q;
    memAddr    = mem_addr_q;
    req0Ack    = ack0_q;
    req1Ack    = ack1_q;
    req0Data   = data0_q;
    req1Data   = data1_q;
    owner      = owner_q;
    timeoutErr = tmo_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_floppy_rom_arbiter.sv
// Directed bench for floppy_rom_arbiter with a short watchdog (TIMEOUT=8).
module tb_floppy_rom_arbiter;

  localparam int unsigned AW = 22;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          _reset = 1'b0;
  logic          req0Valid = 1'b0;
  logic [AW-1:0] req0Addr = '0;
  logic          req0Ack;
  logic [7:0]    req0Data;
  logic          req1Valid = 1'b0;
  logic [AW-1:0] req1Addr = '0;
  logic          req1Ack;
  logic [7:0]    req1Data;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memAck = 1'b0;
  logic [7:0]    memData = 8'h00;
  logic          busy;
  logic          owner;
  logic          timeoutErr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_overlap = 0;

  floppy_rom_arbiter #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) u_dut (
    .clk        (clk),
    ._reset     (_reset),
    .req0Valid  (req0Valid),
    .req0Addr   (req0Addr),
    .req0Ack    (req0Ack),
    .req0Data   (req0Data),
    .req1Valid  (req1Valid),
    .req1Addr   (req1Addr),
    .req1Ack    (req1Ack),
    .req1Data   (req1Data),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .busy       (busy),
    .owner      (owner),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (req0Ack && req1Ack) n_overlap++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    _reset = 1'b0;
    tick();
    tick();
    _reset = 1'b1;
    tick();
  endtask

  // Bounded wait for memReq to rise.
  task automatic wait_memreq(input string tag);
    int n = 0;
    while (!memReq && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(memReq), 32'd1);
  endtask

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  logic [AW-1:0] addr0, addr1;
  int            cnt;

  initial begin
    // Reset values
    tick();
    chk("rst_memReq",   32'(memReq),   32'd0);
    chk("rst_memAddr",  32'(memAddr),  32'd0);
    chk("rst_ack0",     32'(req0Ack),  32'd0);
    chk("rst_ack1",     32'(req1Ack),  32'd0);
    chk("rst_data0",    32'(req0Data), 32'd0);
    chk("rst_data1",    32'(req1Data), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_owner",    32'(owner),    32'd0);
    chk("rst_tmo",      32'(timeoutErr), 32'd0);
    _reset = 1'b1;
    tick();

    // 1. Single request
    req0Valid = 1'b1;
    req0Addr  = 22'h012345;
    tick();
    chk("t1_memReq",  32'(memReq),  32'd1);
    chk("t1_memAddr", 32'(memAddr), 32'h012345);
    chk("t1_busy",    32'(busy),    32'd1);
    tick();
    tick();
    memAck  = 1'b1;
    memData = 8'hA5;
    tick();
    memAck  = 1'b0;
    chk("t1_ack0",   32'(req0Ack),  32'd1);
    chk("t1_data0",  32'(req0Data), 32'hA5);
    chk("t1_owner",  32'(owner),    32'd0);
    chk("t1_memReq_low", 32'(memReq), 32'd0);
    req0Valid = 1'b0;
    tick();
    chk("t1_ack0_pulse", 32'(req0Ack), 32'd0);
    chk("t1_busy_low",   32'(busy),    32'd0);
    chk("t1_data0_hold", 32'(req0Data), 32'hA5);

    // 2. Tie and fairness: both requesters held continuously
    do_reset();
    addr0 = 22'h000010;
    addr1 = 22'h000200;
    req0Addr = addr0;
    req1Addr = addr1;
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_memreq($sformatf("t2_memReq%0d", i));
      chk($sformatf("t2_owner%0d", i), 32'(owner), 32'(i % 2));
      chk($sformatf("t2_addr%0d", i), 32'(memAddr), 32'((i % 2) ? addr1 : addr0));
      tick();
      memAck  = 1'b1;
      memData = mem_byte(memAddr);
      tick();
      memAck  = 1'b0;
      if (i % 2 == 0) begin
        chk($sformatf("t2_ack0_%0d", i), 32'(req0Ack), 32'd1);
        chk($sformatf("t2_data0_%0d", i), 32'(req0Data), 32'(mem_byte(addr0)));
        addr0 = addr0 + 22'd7;
        req0Addr = addr0;
      end else begin
        chk($sformatf("t2_ack1_%0d", i), 32'(req1Ack), 32'd1);
        chk($sformatf("t2_data1_%0d", i), 32'(req1Data), 32'(mem_byte(addr1)));
        addr1 = addr1 + 22'd3;
        req1Addr = addr1;
      end
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    tick();
    tick();
    chk("t2_no_overlap", 32'(n_overlap), 32'd0);

    // 3. Timeout on requester 1
    req1Valid = 1'b1;
    req1Addr  = 22'h2AAAAA;
    wait_memreq("t3_memReq");
    cnt = 0;
    while (memReq && cnt < 50) begin
      cnt++;
      tick();
    end
    chk("t3_memReq_cycles", 32'(cnt), 32'(TO));
    chk("t3_tmo",   32'(timeoutErr), 32'd1);
    chk("t3_ack1",  32'(req1Ack),    32'd1);
    chk("t3_data1", 32'(req1Data),   32'hFF);
    req1Valid = 1'b0;
    tick();
    chk("t3_tmo_pulse", 32'(timeoutErr), 32'd0);
    tick();
    memAck  = 1'b1;
    memData = 8'h77;
    tick();
    memAck  = 1'b0;
    chk("t3_late_memReq", 32'(memReq),   32'd0);
    chk("t3_late_busy",   32'(busy),     32'd0);
    chk("t3_late_ack1",   32'(req1Ack),  32'd0);
    chk("t3_late_data1",  32'(req1Data), 32'hFF);

    // 4. Ack on the last allowed cycle
    req0Valid = 1'b1;
    req0Addr  = 22'h00ABCD;
    wait_memreq("t4_memReq");
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t4_memReq_still", 32'(memReq), 32'd1);
    memAck  = 1'b1;
    memData = 8'h42;
    tick();
    memAck  = 1'b0;
    chk("t4_ack0",  32'(req0Ack),    32'd1);
    chk("t4_data0", 32'(req0Data),   32'h42);
    chk("t4_tmo",   32'(timeoutErr), 32'd0);
    req0Valid = 1'b0;
    tick();
    tick();

    // 5. Abandoned request, pending requester 1 served next
    req0Valid = 1'b1;
    req0Addr  = 22'h001111;
    wait_memreq("t5_memReq0");
    req1Valid = 1'b1;
    req1Addr  = 22'h002222;
    tick();
    req0Valid = 1'b0;
    tick();
    tick();
    chk("t5_memReq_held", 32'(memReq),  32'd1);
    chk("t5_memAddr",     32'(memAddr), 32'h001111);
    memAck  = 1'b1;
    memData = 8'h99;
    tick();
    memAck  = 1'b0;
    chk("t5_no_ack0",  32'(req0Ack),  32'd0);
    chk("t5_data0_old", 32'(req0Data), 32'h42);
    wait_memreq("t5_memReq1");
    chk("t5_owner1",   32'(owner),   32'd1);
    chk("t5_addr1",    32'(memAddr), 32'h002222);
    memAck  = 1'b1;
    memData = 8'h5E;
    tick();
    memAck  = 1'b0;
    chk("t5_ack1",  32'(req1Ack),  32'd1);
    chk("t5_data1", 32'(req1Data), 32'h5E);
    req1Valid = 1'b0;
    tick();
    tick();

    // 6. Reset in the middle of WAIT
    req0Valid = 1'b1;
    req0Addr  = 22'h003333;
    wait_memreq("t6_memReq");
    tick();
    _reset = 1'b0;
    #1;
    chk("t6_memReq_async", 32'(memReq),   32'd0);
    chk("t6_memAddr",      32'(memAddr),  32'd0);
    chk("t6_busy",         32'(busy),     32'd0);
    chk("t6_owner",        32'(owner),    32'd0);
    chk("t6_data0",        32'(req0Data), 32'd0);
    chk("t6_data1",        32'(req1Data), 32'd0);
    req0Valid = 1'b0;
    tick();
    _reset = 1'b1;
    tick();
    req0Valid = 1'b1;
    req0Addr  = 22'h004444;
    wait_memreq("t6_memReq_new");
    chk("t6_memAddr_new", 32'(memAddr), 32'h004444);
    tick();
    tick();
    memAck  = 1'b1;
    memData = 8'hC3;
    tick();
    memAck  = 1'b0;
    chk("t6_ack0",  32'(req0Ack),  32'd1);
    chk("t6_data0_new", 32'(req0Data), 32'hC3);
    req0Valid = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    chk("final_no_overlap", 32'(n_overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
